spi_arbiter: RTL
================

SPI_ARBITER -- requirements
Module: spi_arbiter

Interface
REQ-001 Parameter NCS, default 8, number of SPI chip selects; legal range 2..8.
REQ-002 Parameter TIMEOUT, default 1023, maximum cycles to wait for spitxready or spirxdv.
REQ-003 clk  input  1  system clock; all logic is on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 reqN_valid  input  1  requester N (N=0,1) has a transaction pending.
REQ-006 reqN_ready  output  1  requester N request accepted this cycle.
REQ-007 reqN_cs  input  3  target chip index.
REQ-008 reqN_three  input  1  1 = 3-byte transfer, 0 = 2-byte transfer.
REQ-009 reqN_data  input  24  bytes to send: [7:0] first, [15:8] second, [23:16] third.
REQ-010 rspN_valid  output  1  one-cycle response strobe to requester N.
REQ-011 rspN_data  output  8  byte read back.
REQ-012 rspN_err  output  1  transaction aborted (timeout or illegal cs).
REQ-013 spitx  output  8  byte to the SPI master.
REQ-014 spitxdv  output  1  one-cycle send strobe.
REQ-015 spitxready  input  1  SPI master is idle.
REQ-016 spirx  input  8  received byte.
REQ-017 spirxdv  input  1  received-byte strobe.
REQ-018 spics  output  NCS  chip selects, active-low.
REQ-019 spimisossel  output  3  MISO mux select.
REQ-020 busy  output  1  a transaction is in progress.
REQ-021 owner  output  1  requester currently granted.

Function
REQ-022 The FSM has states IDLE, LOAD, WAIT_RDY, SEND, WAIT_RX, DONE.
REQ-023 In IDLE with any reqN_valid, arbitration is round-robin: the requester not served last wins a tie; after reset, requester 0 wins a tie.
REQ-024 Acceptance:
- reqN_ready pulses for exactly one cycle in IDLE for the winner only.
- reqN_cs, reqN_three and reqN_data are latched on that cycle.
- Later changes to the reqN inputs have no effect on the transaction.
REQ-025 If the latched cs >= NCS:
- the bus is not touched; the FSM goes directly to DONE;
- rspN_err=1 and rspN_data=0x00.
REQ-026 LOAD:
- spics[cs]=0, all other spics bits 1;
- spimisossel=cs; spitx=first byte; byte counter=0;
- next state is WAIT_RDY.
REQ-027 WAIT_RDY: when spitxready=1, go to SEND.
REQ-028 SEND:
- spitxdv=1 for exactly one cycle;
- if more bytes remain, load the next byte into spitx, increment the counter and return to WAIT_RDY;
- otherwise go to WAIT_RX.
REQ-029 Transfer sizes:
- a 2-byte transfer issues exactly 2 spitxdv pulses;
- a 3-byte transfer issues exactly 3 spitxdv pulses;
- spitxdv is never asserted while spitxready=0.
REQ-030 WAIT_RX: on spirxdv=1, latch spirx as the response data with err=0, then go to DONE.
REQ-031 spirxdv pulses that arrive before the last byte is sent are ignored.
REQ-032 Timeout:
- a counter clears on each entry to WAIT_RDY or WAIT_RX and increments each cycle spent there;
- when it reaches TIMEOUT, go to DONE with err=1 and data=0x00.
REQ-033 DONE:
- all spics bits = 1;
- rspN_valid=1 for one cycle to the owner only;
- next state is IDLE.
REQ-034 A new request is not accepted earlier than the cycle after DONE, giving one full idle cycle with all chip selects high between transactions.
REQ-035 busy=1 in every state except IDLE.
REQ-036 owner holds the last granted requester until the next grant.

Reset
REQ-037 While rst=1, and asynchronously on its assertion:
- state=IDLE; spics all 1; spitxdv=0; spitx=0; spimisossel=0;
- reqN_ready=0; rspN_valid=0; rspN_data=0; rspN_err=0;
- busy=0; owner=0; round-robin pointer favours requester 0.
REQ-038 Reset asserted mid-transaction:
- the transaction is abandoned with no rspN_valid;
- chip selects are released within the same cycle, asynchronously;
- the requester reissues the request after reset.

Verification
REQ-039 2-byte transfer: req0 cs=3, three=0, data=0x00_51_80; SPI model returns 0xA5 -> spitx 0x80 then 0x51; exactly 2 spitxdv; spics=0xF7 throughout; rsp0_valid with data=0xA5, err=0.
REQ-040 Simultaneous requests after reset, both valid in the same cycle -> req0 granted first, req1 granted next; between them one idle cycle with spics=0xFF; rsp0 precedes rsp1.
REQ-041 Fairness: req0 held continuously valid while req1 pulses -> grants alternate 0,1,0,1; no requester is starved.
REQ-042 Timeout: spitxready held 0 after grant -> no spitxdv pulses; at TIMEOUT+few cycles rsp err=1, data=0x00, spics=0xFF.
REQ-043 Illegal cs with NCS=4: req1 cs=6 -> spics stays 0xF, no spitxdv pulses; rsp1_err=1 within 3 cycles.
REQ-044 Reset mid-operation: assert rst while in WAIT_RX of a 3-byte transfer -> spics all 1 and spitxdv=0 immediately; no rsp strobe; next request completes normally.

Source files
------------

// File: rtl/spi_arbiter_if.sv
// ============================================================================
//  Module   : spi_arbiter_if
//  Brief    : Requester and SPI-master bus bundle for spi_arbiter.
//  Revision : 1.0
// ============================================================================
`default_nettype none

interface spi_arbiter_if #(
    parameter int NCS = 8
);
    logic            req0_valid;
    logic            req0_ready;
    logic [2:0]      req0_cs;
    logic            req0_three;
    logic [23:0]     req0_data;
    logic            rsp0_valid;
    logic [7:0]      rsp0_data;
    logic            rsp0_err;

    logic            req1_valid;
    logic            req1_ready;
    logic [2:0]      req1_cs;
    logic            req1_three;
    logic [23:0]     req1_data;
    logic            rsp1_valid;
    logic [7:0]      rsp1_data;
    logic            rsp1_err;

    logic [7:0]      spitx;
    logic            spitxdv;
    logic            spitxready;
    logic [7:0]      spirx;
    logic            spirxdv;
    logic [NCS-1:0]  spics;
    logic [2:0]      spimisossel;
    logic            busy;
    logic            owner;

    modport slave (
        input  req0_valid, req0_cs, req0_three, req0_data,
        input  req1_valid, req1_cs, req1_three, req1_data,
        input  spitxready, spirx, spirxdv,
        output req0_ready, rsp0_valid, rsp0_data, rsp0_err,
        output req1_ready, rsp1_valid, rsp1_data, rsp1_err,
        output spitx, spitxdv, spics, spimisossel, busy, owner
    );

    modport master (
        output req0_valid, req0_cs, req0_three, req0_data,
        output req1_valid, req1_cs, req1_three, req1_data,
        output spitxready, spirx, spirxdv,
        input  req0_ready, rsp0_valid, rsp0_data, rsp0_err,
        input  req1_ready, rsp1_valid, rsp1_data, rsp1_err,
        input  spitx, spitxdv, spics, spimisossel, busy, owner
    );
endinterface

`default_nettype wire

// File: rtl/spi_arbiter.sv
// ============================================================================
//  Module   : spi_arbiter
//  Brief    : Two-requester round-robin arbiter driving a byte-wide SPI master.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module spi_arbiter #(
    parameter int NCS     = 8,
    parameter int TIMEOUT = 1023
) (
    input  logic         clk,
    input  logic         rst,
    spi_arbiter_if.slave bus
);
    localparam int             c_tmo_w   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [c_tmo_w-1:0] c_tmo_max = c_tmo_w'(TIMEOUT);
    localparam logic [NCS-1:0] c_cs_idle = {NCS{1'b1}};
    localparam logic [NCS-1:0] c_cs_one  = {{(NCS-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD     = 3'd1,
        S_WAIT_RDY = 3'd2,
        S_SEND     = 3'd3,
        S_WAIT_RX  = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    state_t               r_state;
    logic [2:0]           r_cs;
    logic                 r_three;
    logic [23:0]          r_data;
    logic [1:0]           r_cnt;
    logic [c_tmo_w-1:0]   r_tmo;
    logic [NCS-1:0]       r_spics;
    logic [2:0]           r_sel;
    logic [7:0]           r_tx;
    logic                 r_txdv;
    logic [1:0]           r_rsp_valid;
    logic [7:0]           r_rsp_data;
    logic                 r_rsp_err;
    logic                 r_busy;
    logic                 r_owner;
    logic                 r_prio;

    logic                 w_win;
    logic                 w_take;
    logic [2:0]           w_cs;
    logic                 w_three;
    logic [23:0]          w_data;
    logic                 w_cs_ok;
    logic [1:0]           w_last;
    logic [7:0]           w_next_byte;

    // Tie goes to r_prio, which always points at the requester not served last.
    always_comb begin
        w_win = r_prio;
        if (bus.req0_valid && !bus.req1_valid) begin
            w_win = 1'b0;
        end else if (!bus.req0_valid && bus.req1_valid) begin
            w_win = 1'b1;
        end
    end

    assign w_take      = (r_state == S_IDLE) && (bus.req0_valid || bus.req1_valid) && !rst;
    assign w_cs        = w_win ? bus.req1_cs    : bus.req0_cs;
    assign w_three     = w_win ? bus.req1_three : bus.req0_three;
    assign w_data      = w_win ? bus.req1_data  : bus.req0_data;
    assign w_cs_ok     = ({29'd0, w_cs} < 32'(NCS));
    assign w_last      = r_three ? 2'd2 : 2'd1;
    assign w_next_byte = (r_cnt == 2'd0) ? r_data[15:8] : r_data[23:16];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cs        <= 3'd0;
            r_three     <= 1'b0;
            r_data      <= 24'd0;
            r_cnt       <= 2'd0;
            r_tmo       <= '0;
            r_spics     <= c_cs_idle;
            r_sel       <= 3'd0;
            r_tx        <= 8'd0;
            r_txdv      <= 1'b0;
            r_rsp_valid <= 2'b00;
            r_rsp_data  <= 8'd0;
            r_rsp_err   <= 1'b0;
            r_busy      <= 1'b0;
            r_owner     <= 1'b0;
            r_prio      <= 1'b0;
        end else begin
            r_rsp_valid <= 2'b00;
            r_txdv      <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_take) begin
                        r_owner <= w_win;
                        r_prio  <= ~w_win;
                        r_cs    <= w_cs;
                        r_three <= w_three;
                        r_data  <= w_data;
                        r_busy  <= 1'b1;
                        if (w_cs_ok) begin
                            r_state <= S_LOAD;
                        end else begin
                            // Out-of-range target: answer with an error without touching the bus.
                            r_state            <= S_DONE;
                            r_rsp_valid[w_win] <= 1'b1;
                            r_rsp_err          <= 1'b1;
                            r_rsp_data         <= 8'd0;
                        end
                    end
                end
                S_LOAD: begin
                    r_spics <= ~(c_cs_one << r_cs);
                    r_sel   <= r_cs;
                    r_tx    <= r_data[7:0];
                    r_cnt   <= 2'd0;
                    r_tmo   <= '0;
                    r_state <= S_WAIT_RDY;
                end
                S_WAIT_RDY: begin
                    if (bus.spitxready) begin
                        r_txdv  <= 1'b1;
                        r_state <= S_SEND;
                    end else if (r_tmo == c_tmo_max) begin
                        r_spics              <= c_cs_idle;
                        r_rsp_valid[r_owner] <= 1'b1;
                        r_rsp_err            <= 1'b1;
                        r_rsp_data           <= 8'd0;
                        r_state              <= S_DONE;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                S_SEND: begin
                    r_tmo <= '0;
                    if (r_cnt != w_last) begin
                        r_tx    <= w_next_byte;
                        r_cnt   <= r_cnt + 2'd1;
                        r_state <= S_WAIT_RDY;
                    end else begin
                        r_state <= S_WAIT_RX;
                    end
                end
                S_WAIT_RX: begin
                    if (bus.spirxdv) begin
                        r_spics              <= c_cs_idle;
                        r_rsp_valid[r_owner] <= 1'b1;
                        r_rsp_err            <= 1'b0;
                        r_rsp_data           <= bus.spirx;
                        r_state              <= S_DONE;
                    end else if (r_tmo == c_tmo_max) begin
                        r_spics              <= c_cs_idle;
                        r_rsp_valid[r_owner] <= 1'b1;
                        r_rsp_err            <= 1'b1;
                        r_rsp_data           <= 8'd0;
                        r_state              <= S_DONE;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_spics <= c_cs_idle;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.req0_ready  = w_take && !w_win;
    assign bus.req1_ready  = w_take && w_win;
    assign bus.rsp0_valid  = r_rsp_valid[0];
    assign bus.rsp1_valid  = r_rsp_valid[1];
    assign bus.rsp0_data   = r_rsp_data;
    assign bus.rsp1_data   = r_rsp_data;
    assign bus.rsp0_err    = r_rsp_err;
    assign bus.rsp1_err    = r_rsp_err;
    assign bus.spitx       = r_tx;
    assign bus.spitxdv     = r_txdv;
    assign bus.spics       = r_spics;
    assign bus.spimisossel = r_sel;
    assign bus.busy        = r_busy;
    assign bus.owner       = r_owner;

endmodule

`default_nettype wire
